// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RISC-V immediate-extraction stage.
// The input word is decoded combinationally into an XLEN-wide immediate.
// The result is then held in a two-entry buffer (output register plus skid
// entry), so that in_ready can come straight from a flop and still sustain
// one beat per cycle.
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high. A producer holds valid and its payload until the transfer happens.
// in_ready depends only on registered state. out_valid/out_* never depend
// combinationally on out_ready, and out_* stay stable while out_valid && !out_ready.
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [2:0]       in_extop,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic             out_err,
   output logic [TAG_W-1:0] out_tag
);

   localparam logic [2:0] EXT_I  = 3'b000;
   localparam logic [2:0] EXT_U  = 3'b001;
   localparam logic [2:0] EXT_S  = 3'b010;
   localparam logic [2:0] EXT_B  = 3'b011;
   localparam logic [2:0] EXT_J  = 3'b100;
   localparam logic [2:0] EXT_Z  = 3'b101;
   localparam logic [2:0] EXT_SH = 3'b110;

   // Registered state: output register and skid entry
   logic             r_out_valid;
   logic [XLEN-1:0]  r_out_imm;
   logic             r_out_err;
   logic [TAG_W-1:0] r_out_tag;
   logic             r_skid_valid;
   logic [XLEN-1:0]  r_skid_imm;
   logic             r_skid_err;
   logic [TAG_W-1:0] r_skid_tag;
   logic             r_in_ready;

   // Decode results and next-state values
   logic [63:0]      w_imm64;
   logic [XLEN-1:0]  w_imm;
   logic             w_err;
   logic             w_in_fire;
   logic             w_out_fire;
   logic             w_unused_bits;

   logic             w_out_valid_nxt;
   logic [XLEN-1:0]  w_out_imm_nxt;
   logic             w_out_err_nxt;
   logic [TAG_W-1:0] w_out_tag_nxt;
   logic             w_skid_valid_nxt;
   logic [XLEN-1:0]  w_skid_imm_nxt;
   logic             w_skid_err_nxt;
   logic [TAG_W-1:0] w_skid_tag_nxt;

   // Build every immediate at 64 bits and truncate to XLEN, so the RV32 and
   // RV64 builds share one set of sign-extension expressions.
   always_comb begin
      w_imm64 = '0;
      w_err   = 1'b0;
      case (in_extop)
         EXT_I:  w_imm64 = {{52{in_inst[31]}}, in_inst[31:20]};
         EXT_U:  w_imm64 = {{32{in_inst[31]}}, in_inst[31:12], 12'h000};
         EXT_S:  w_imm64 = {{52{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
         EXT_B:  w_imm64 = {{51{in_inst[31]}}, in_inst[31], in_inst[7],
                            in_inst[30:25], in_inst[11:8], 1'b0};
         EXT_J:  w_imm64 = {{43{in_inst[31]}}, in_inst[31], in_inst[19:12],
                            in_inst[20], in_inst[30:21], 1'b0};
         EXT_Z:  w_imm64 = {59'd0, in_inst[19:15]};
         EXT_SH: begin
            if (XLEN == 64) w_imm64 = {58'd0, in_inst[25:20]};
            else            w_imm64 = {59'd0, in_inst[24:20]};
         end
         default: begin
            w_imm64 = '0;
            w_err   = 1'b1;
         end
      endcase
   end

   assign w_imm      = w_imm64[XLEN-1:0];
   // Opcode bits are deliberately ignored here. Upper decode bits are unused in RV32.
   assign w_unused_bits = ^{in_inst[6:0], w_imm64};

   assign w_in_fire  = in_valid && r_in_ready;
   assign w_out_fire = r_out_valid && out_ready;

   // Next state of the two-entry buffer. Flush overrides all handshakes.
   always_comb begin
      w_out_valid_nxt  = r_out_valid;
      w_out_imm_nxt    = r_out_imm;
      w_out_err_nxt    = r_out_err;
      w_out_tag_nxt    = r_out_tag;
      w_skid_valid_nxt = r_skid_valid;
      w_skid_imm_nxt   = r_skid_imm;
      w_skid_err_nxt   = r_skid_err;
      w_skid_tag_nxt   = r_skid_tag;
      if (!r_out_valid || w_out_fire) begin
         if (r_skid_valid) begin
            // Skid is older than any incoming beat, so it goes out first.
            w_out_valid_nxt = 1'b1;
            w_out_imm_nxt   = r_skid_imm;
            w_out_err_nxt   = r_skid_err;
            w_out_tag_nxt   = r_skid_tag;
            if (w_in_fire) begin
               w_skid_imm_nxt = w_imm;
               w_skid_err_nxt = w_err;
               w_skid_tag_nxt = in_tag;
            end else begin
               w_skid_valid_nxt = 1'b0;
            end
         end else if (w_in_fire) begin
            w_out_valid_nxt = 1'b1;
            w_out_imm_nxt   = w_imm;
            w_out_err_nxt   = w_err;
            w_out_tag_nxt   = in_tag;
         end else begin
            w_out_valid_nxt = 1'b0;
         end
      end else if (w_in_fire) begin
         w_skid_valid_nxt = 1'b1;
         w_skid_imm_nxt   = w_imm;
         w_skid_err_nxt   = w_err;
         w_skid_tag_nxt   = in_tag;
      end
      if (flush) begin
         w_out_valid_nxt  = 1'b0;
         w_skid_valid_nxt = 1'b0;
      end
   end

   // State register. Reset clears everything immediately, without waiting for a clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid  <= 1'b0;
         r_out_imm    <= '0;
         r_out_err    <= 1'b0;
         r_out_tag    <= '0;
         r_skid_valid <= 1'b0;
         r_skid_imm   <= '0;
         r_skid_err   <= 1'b0;
         r_skid_tag   <= '0;
         r_in_ready   <= 1'b1;
      end else begin
         r_out_valid  <= w_out_valid_nxt;
         r_out_imm    <= w_out_imm_nxt;
         r_out_err    <= w_out_err_nxt;
         r_out_tag    <= w_out_tag_nxt;
         r_skid_valid <= w_skid_valid_nxt;
         r_skid_imm   <= w_skid_imm_nxt;
         r_skid_err   <= w_skid_err_nxt;
         r_skid_tag   <= w_skid_tag_nxt;
         r_in_ready   <= !w_skid_valid_nxt;
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_imm   = r_out_imm;
   assign out_err   = r_out_err;
   assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed bench for imm_gen_pipe.
// An RV32 instance and an RV64 instance share all inputs.
module tb_imm_gen_pipe;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_inst;
   logic [2:0]  in_extop;
   logic [31:0] in_tag;

   logic        in_ready_32, out_valid_32, out_err_32;
   logic [31:0] out_imm_32, out_tag_32;
   logic        in_ready_64, out_valid_64, out_err_64;
   logic [63:0] out_imm_64;
   logic [31:0] out_tag_64;

   imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u_dut32 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_32),
      .in_inst(in_inst), .in_extop(in_extop), .in_tag(in_tag),
      .out_valid(out_valid_32), .out_ready(out_ready),
      .out_imm(out_imm_32), .out_err(out_err_32), .out_tag(out_tag_32)
   );

   imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u_dut64 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_64),
      .in_inst(in_inst), .in_extop(in_extop), .in_tag(in_tag),
      .out_valid(out_valid_64), .out_ready(out_ready),
      .out_imm(out_imm_64), .out_err(out_err_64), .out_tag(out_tag_64)
   );

   // ---------------- scoreboard ----------------
   int          tests_run    = 0;
   int          tests_failed = 0;
   logic [31:0] exp_q[$];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      assert (got === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Check both instances against one expected beat.
   task automatic expect_out(input string name, input logic [63:0] e32, input logic [63:0] e64,
                             input logic e_err, input logic [31:0] e_tag);
      chk({name, " valid32"}, {63'd0, out_valid_32}, 64'd1);
      chk({name, " valid64"}, {63'd0, out_valid_64}, 64'd1);
      chk({name, " imm32"},   {32'd0, out_imm_32}, e32);
      chk({name, " imm64"},   out_imm_64, e64);
      chk({name, " err32"},   {63'd0, out_err_32}, {63'd0, e_err});
      chk({name, " err64"},   {63'd0, out_err_64}, {63'd0, e_err});
      chk({name, " tag32"},   {32'd0, out_tag_32}, {32'd0, e_tag});
      chk({name, " tag64"},   {32'd0, out_tag_64}, {32'd0, e_tag});
   endtask

   task automatic chk_ctrl(input string name, input logic e_valid, input logic e_ready);
      chk({name, " out_valid32"}, {63'd0, out_valid_32}, {63'd0, e_valid});
      chk({name, " out_valid64"}, {63'd0, out_valid_64}, {63'd0, e_valid});
      chk({name, " in_ready32"},  {63'd0, in_ready_32},  {63'd0, e_ready});
      chk({name, " in_ready64"},  {63'd0, in_ready_64},  {63'd0, e_ready});
   endtask

   // Pop the oldest expected tag and compare it with the delivered beat.
   task automatic chk_order(input string name);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         chk({name, " queue empty"}, 64'd1, 64'd0);
      end else begin
         e = exp_q.pop_front();
         chk({name, " order32"}, {32'd0, out_tag_32}, {32'd0, e});
         chk({name, " order64"}, {32'd0, out_tag_64}, {32'd0, e});
      end
   endtask

   // ---------------- drivers ----------------
   task automatic drive(input logic [31:0] inst, input logic [2:0] extop, input logic [31:0] tag);
      in_valid = 1'b1;
      in_inst  = inst;
      in_extop = extop;
      in_tag   = tag;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      in_inst   = 32'd0;
      in_extop  = 3'd0;
      in_tag    = 32'd0;
      repeat (2) tick();

      // Reset state
      chk_ctrl("reset", 1'b0, 1'b1);
      chk("reset imm32", {32'd0, out_imm_32}, 64'd0);
      chk("reset imm64", out_imm_64, 64'd0);
      chk("reset err",   {63'd0, out_err_32}, 64'd0);
      chk("reset tag",   {32'd0, out_tag_32}, 64'd0);
      rst = 1'b0;
      tick();

      // Back-to-back beats, one per cycle, no backpressure
      drive(32'hFFF00093, 3'b000, 32'h8000_0000); tick();
      expect_out("I",  64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32'h8000_0000);
      drive(32'h80000F80, 3'b010, 32'h0000_0011); tick();
      expect_out("S",  64'hFFFF_F81F, 64'hFFFF_FFFF_FFFF_F81F, 1'b0, 32'h0000_0011);
      drive(32'hFE000EE3, 3'b011, 32'h0000_0022); tick();
      expect_out("B",  64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'h0000_0022);
      drive(32'h0080006F, 3'b100, 32'h0000_0033); tick();
      expect_out("J",  64'h0000_0008, 64'h0000_0000_0000_0008, 1'b0, 32'h0000_0033);
      drive(32'h800002B7, 3'b001, 32'h0000_0044); tick();
      expect_out("U",  64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0, 32'h0000_0044);
      drive(32'h03F09093, 3'b110, 32'h0000_0055); tick();
      expect_out("SH", 64'h0000_001F, 64'h0000_0000_0000_003F, 1'b0, 32'h0000_0055);
      drive(32'h000FD073, 3'b101, 32'h0000_0066); tick();
      expect_out("Z",  64'h0000_001F, 64'h0000_0000_0000_001F, 1'b0, 32'h0000_0066);
      drive(32'hFFFFFFFF, 3'b111, 32'h0000_0077); tick();
      expect_out("ILL", 64'h0, 64'h0, 1'b1, 32'h0000_0077);
      in_valid = 1'b0;
      tick();
      chk_ctrl("drained", 1'b0, 1'b1);

      // Backpressure: A in output register, B in skid, C held off
      out_ready = 1'b0;
      drive(32'h00100093, 3'b000, 32'h0000_00A0); tick();
      exp_q.push_back(32'h0000_00A0);
      chk_ctrl("bp A", 1'b1, 1'b1);
      chk("bp A tag", {32'd0, out_tag_32}, 64'h0000_00A0);
      drive(32'h00200093, 3'b000, 32'h0000_00B0); tick();
      exp_q.push_back(32'h0000_00B0);
      chk_ctrl("bp B", 1'b1, 1'b0);
      chk("bp hold imm", {32'd0, out_imm_32}, 64'd1);
      drive(32'h00300093, 3'b000, 32'h0000_00C0); tick();
      chk_ctrl("bp C held", 1'b1, 1'b0);
      chk("bp stable tag", {32'd0, out_tag_32}, 64'h0000_00A0);
      chk("bp stable imm", {32'd0, out_imm_32}, 64'd1);
      out_ready = 1'b1;
      chk_order("bp A out");
      tick();  // A drains, B skid->out, C not accepted (in_ready was 0)
      chk_ctrl("bp B out", 1'b1, 1'b1);
      chk_order("bp B out");
      chk("bp B imm", {32'd0, out_imm_32}, 64'd2);
      tick();  // B drains, C accepted directly into output register
      exp_q.push_back(32'h0000_00C0);
      in_valid = 1'b0;
      chk_ctrl("bp C out", 1'b1, 1'b1);
      chk_order("bp C out");
      chk("bp C imm", {32'd0, out_imm_32}, 64'd3);
      tick();
      chk_ctrl("bp empty", 1'b0, 1'b1);
      chk("bp queue empty", 64'(exp_q.size()), 64'd0);

      // Flush with two beats buffered; beat offered during flush is dropped
      out_ready = 1'b0;
      drive(32'h00400093, 3'b000, 32'h0000_00D0); tick();
      drive(32'h00500093, 3'b000, 32'h0000_00E0); tick();
      chk_ctrl("pre-flush", 1'b1, 1'b0);
      flush = 1'b1;
      drive(32'h00600093, 3'b000, 32'h0000_00F0); tick();
      flush = 1'b0;
      in_valid = 1'b0;
      chk_ctrl("flush", 1'b0, 1'b1);
      out_ready = 1'b1;
      drive(32'h00700093, 3'b000, 32'h0000_0070); tick();
      in_valid = 1'b0;
      expect_out("post-flush", 64'd7, 64'd7, 1'b0, 32'h0000_0070);
      tick();
      chk_ctrl("post-flush alone", 1'b0, 1'b1);

      // Asynchronous reset mid-stream, checked before any clock edge
      out_ready = 1'b0;
      drive(32'hFFF00093, 3'b000, 32'h0000_0123); tick();
      drive(32'h00100093, 3'b000, 32'h0000_0456); tick();
      in_valid = 1'b0;
      chk_ctrl("pre-rst", 1'b1, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk_ctrl("async rst", 1'b0, 1'b1);
      chk("async rst imm32", {32'd0, out_imm_32}, 64'd0);
      chk("async rst imm64", out_imm_64, 64'd0);
      chk("async rst tag",   {32'd0, out_tag_32}, 64'd0);
      chk("async rst err",   {63'd0, out_err_64}, 64'd0);
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      tick();
      chk_ctrl("after rst", 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Watchdog so the run always ends
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
